// File: rtl/mbscore_rf_bank.sv
// ============================================================================
// mbscore_rf_bank : MBScore GPR/SPR register bank with write bypass and irq entry
// Revision 1.0
// ============================================================================
`default_nettype none

module mbscore_rf_bank #(
  parameter int DATA_W = 32,
  parameter int GPR_AW = 5,
  parameter int SPR_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GPR_AW-1:0] rs_addr,
  input  logic [GPR_AW-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_out,
  output logic [DATA_W-1:0] rt_out,
  input  logic              wa_en,
  input  logic [GPR_AW-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wa_lui,
  input  logic              wm_en,
  input  logic [GPR_AW-1:0] wm_addr,
  input  logic [DATA_W-1:0] wm_data,
  input  logic              link_en,
  input  logic [DATA_W-1:0] link_pc,
  input  logic              spr_we,
  input  logic [SPR_AW-1:0] spr_waddr,
  input  logic [DATA_W-1:0] spr_mask,
  input  logic [DATA_W-1:0] spr_wdata,
  input  logic [SPR_AW-1:0] spr_raddr,
  output logic [DATA_W-1:0] spr_out,
  input  logic              irq_req,
  input  logic [DATA_W-1:0] irq_pc,
  input  logic              eret,
  output logic              int_en_n,
  output logic [DATA_W-1:0] epc,
  output logic              irq_taken,
  output logic              irq_pending
);

  localparam int                NGPR   = 2**GPR_AW;
  localparam int                NSPR   = 2**SPR_AW;
  localparam logic [GPR_AW-1:0] LINK_A = '1;

  logic [DATA_W-1:0] gr      [NGPR];
  logic [DATA_W-1:0] spr     [NSPR];
  logic [DATA_W-1:0] spr_nxt [NSPR];
  logic [GPR_AW-1:0] rs_addr_r, rt_addr_r;
  logic [SPR_AW-1:0] spr_raddr_r;
  logic              pending_r, irq_taken_r;

  logic [DATA_W-1:0] wa_val, link_val;
  logic              take;

  assign wa_val   = wa_lui ? DATA_W'({wa_data[15:0], 16'h0000}) : wa_data;
  assign link_val = link_pc + DATA_W'(4);
  assign take     = (irq_req | pending_r) & ~spr[1][0];

  // Value a GPR takes at the next edge: link beats memory beats ALU.
  function automatic logic [DATA_W-1:0] gpr_win(input logic [GPR_AW-1:0] a,
                                                input logic [DATA_W-1:0] cur);
    if (link_en && a == LINK_A) return link_val;
    if (wm_en && wm_addr == a)  return wm_data;
    if (wa_en && wa_addr == a)  return wa_val;
    return cur;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NGPR; i++) gr[i] <= '0;
    end else begin
      gr[0] <= '0;
      for (int i = 1; i < NGPR; i++) gr[i] <= gpr_win(GPR_AW'(i), gr[i]);
    end
  end

  always_comb begin
    rs_out = (rs_addr_r == '0) ? '0 : gpr_win(rs_addr_r, gr[rs_addr_r]);
    rt_out = (rt_addr_r == '0) ? '0 : gpr_win(rt_addr_r, gr[rt_addr_r]);
  end

  // Ordering encodes priority: masked write over eret, interrupt entry over both.
  always_comb begin
    for (int a = 0; a < NSPR; a++) begin
      spr_nxt[a] = spr[a];
      if (spr_we && spr_waddr == SPR_AW'(a))
        spr_nxt[a] = (spr[a] & ~spr_mask) | (spr_wdata & spr_mask);
    end
    if (eret && !(spr_we && spr_waddr == SPR_AW'(1) && spr_mask[0]))
      spr_nxt[1][0] = 1'b0;
    if (take) begin
      spr_nxt[0]    = irq_pc;
      spr_nxt[1][0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < NSPR; a++) spr[a] <= '0;
      rs_addr_r   <= '0;
      rt_addr_r   <= '0;
      spr_raddr_r <= '0;
      pending_r   <= 1'b0;
      irq_taken_r <= 1'b0;
    end else begin
      for (int a = 0; a < NSPR; a++) spr[a] <= spr_nxt[a];
      rs_addr_r   <= rs_addr;
      rt_addr_r   <= rt_addr;
      spr_raddr_r <= spr_raddr;
      irq_taken_r <= take;
      if (take)
        pending_r <= 1'b0;
      else if (irq_req)
        pending_r <= 1'b1;
    end
  end

  assign spr_out     = spr[spr_raddr_r];
  assign epc         = spr[0];
  assign int_en_n    = spr[1][0];
  assign irq_taken   = irq_taken_r;
  assign irq_pending = pending_r;

endmodule

`default_nettype wire
